ram_sync_param: RTL and testbench
=================================

// Module: ram_sync_param
//
// PURPOSE
//  Parametrised synchronous RAM for the 8-bit CPU datapath. It is the clocked,
//  generalised successor of the 16x4 scratch RAM. It keeps the active-low CS/WE
//  pin semantics and the optional complemented read data.
//  Additions:
//   - registered reads with a valid strobe (no tri-state);
//   - an automatic clear sequencer after reset or on request;
//   - a priority program-load port used by the boot loader.
//
// PARAMETERS
//  DATA_W     8      data word width, bits (>=1)
//  ADDR_W     4      address width; DEPTH = 2**ADDR_W words
//  OUT_INV    0      1: dout = ~mem[addr] (74189-compatible); 0: true data
//  CLEAR_VAL  0      word value written to every location by the clear sequencer
//
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  cs_n        in   1       active-low chip select, CPU port
//  we_n        in   1       active-low write enable, CPU port
//  addr        in   ADDR_W  CPU address
//  din         in   DATA_W  CPU write data
//  dout        out  DATA_W  registered read data
//  dout_valid  out  1       1-cycle strobe: dout updated by a read
//  ld_en       in   1       program-load write strobe (priority over CPU)
//  ld_addr     in   ADDR_W  load address
//  ld_data     in   DATA_W  load data
//  clear_req   in   1       start a full clear (sampled in IDLE or CLEAR)
//  busy        out  1       1 while the clear sequencer owns the array
//
// BEHAVIOUR
//  - Reset (async): state=CLEAR, clr_cnt=0, busy=1, dout=0, dout_valid=0.
//    Array contents are undefined until the clear completes.
//  - FSM states: CLEAR, IDLE.
//  - CLEAR: each clk writes CLEAR_VAL to mem[clr_cnt], then clr_cnt++.
//    After the write at DEPTH-1, go to IDLE; busy drops to 0 on that same edge.
//    A clear therefore takes exactly DEPTH cycles.
//  - CLEAR: CPU and load accesses are ignored; dout holds; dout_valid=0.
//    clear_req in CLEAR restarts the sweep at clr_cnt=0.
//  - IDLE: clear_req=1 -> CLEAR next edge, clr_cnt=0, busy=1.
//    Any access in that same cycle is still performed.
//  - IDLE access priority, evaluated per cycle:
//     1. ld_en=1: mem[ld_addr] <= ld_data. A concurrent CPU read or write is
//        dropped, and dout_valid=0.
//     2. cs_n=0, we_n=0: mem[addr] <= din. dout holds; dout_valid=0.
//     3. cs_n=0, we_n=1: dout <= OUT_INV ? ~mem[addr] : mem[addr].
//        dout_valid=1 on the following cycle only.
//        Read latency is 1 clk: address at edge N, data valid after edge N+1.
//     4. cs_n=1: no access; dout holds; dout_valid=0.
//  - Read data always reflects contents written before the sampling edge.
//    A write at edge N is visible to a read issued at edge N+1.
//  - Address counter wraps only through the CLEAR->IDLE exit and never
//    overflows into IDLE. CPU addresses cover the full DEPTH, so no
//    out-of-range case exists.
//  - Mid-operation reset: aborts any access or clear immediately and
//    re-enters CLEAR from address 0.
//  - Widths: all data paths are exactly DATA_W. Inversion is bitwise.
//    clr_cnt is ADDR_W bits plus a terminal flag.
//
// STRUCTURE
//  - Shared header ram_defs.vh: FSM state encodings (ST_CLEAR=1'b0,
//    ST_IDLE=1'b1) and the default localparams, for reuse by the boot loader.
//  - One sub-module: ram_array. It holds the DATA_W x DEPTH register array,
//    with one synchronous write port (we, waddr, wdata) and one combinational
//    read port.
//  - The top level contains the FSM, the clear counter, the write-port mux
//    (clear > load > CPU), and the dout/dout_valid registers with OUT_INV.
//
// TESTING (DATA_W=8, ADDR_W=4, CLEAR_VAL=0 unless noted)
//  1. Reset clear: deassert rst.
//     -> busy=1 for exactly 16 clks, then 0.
//     -> Reading all 16 addresses returns 8'h00 with dout_valid pulsed once each.
//  2. Write/read: write 8'hA5 to addr 3, then read addr 3 on the next cycle.
//     -> dout=8'hA5 one clk later, dout_valid=1 for one cycle.
//     Repeat with OUT_INV=1 -> dout=8'h5A.
//  3. Load priority: in the same cycle set ld_en (ld_addr=7, ld_data=8'h3C)
//     and CPU write (addr=7, din=8'hFF).
//     -> A read of 7 returns 8'h3C.
//     -> A concurrent CPU read returns dout_valid=0 and dout unchanged.
//  4. Clear mid-use: fill the RAM with 8'h11, pulse clear_req in IDLE, then
//     pulse it again after 5 clks.
//     -> busy lasts 5+16 cycles; all words read 8'h00.
//     -> Accesses issued during busy have no effect.
//  5. Async reset mid-clear: assert rst between edges at clr_cnt=9.
//     -> dout=0, dout_valid=0 and busy=1 immediately, without waiting for clk.
//     -> After release, a full 16-cycle clear follows.
//  6. Parameter sweep: DATA_W=4, ADDR_W=6, CLEAR_VAL=4'hF.
//     -> busy lasts 64 clks; address 63 reads 4'hF.
//     -> Write/read of addr 0 and addr 63 are correct.

Source files
------------

// File: rtl/ram_sync_param_pkg.sv
// Shared definitions for the synchronous RAM: FSM state encodings and default sizes,
// kept in one place so the boot loader can reuse them.
package ram_sync_param_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;

endpackage

// File: rtl/ram_sync_param_array.sv
// DATA_W x 2**ADDR_W register array: one synchronous write port, one combinational read port.
module ram_sync_param_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // No reset on the storage; the clear sequencer initialises it.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised synchronous RAM with registered reads, an automatic clear sequencer
// and a priority program-load port (write priority: clear > load > CPU).
module ram_sync_param
  import ram_sync_param_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter bit                OUT_INV   = 1'b0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              clear_req,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              clr_done_c;

  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              rd_en_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] dout_nxt_c;

  // Terminal flag: the current sweep write targets the last word.
  assign clr_done_c = (clr_cnt == ADDR_W'(DEPTH - 1));

  // State register and clear counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next-state logic; a clear request always restarts the sweep from address 0.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        if (clear_req) begin
          clr_cnt_nxt = '0;
        end else if (clr_done_c) begin
          state_nxt   = ST_IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
    endcase
  end

  // Write-port mux and read decode.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = addr;
    wr_data_c = din;
    rd_en_c   = 1'b0;
    case (state)
      ST_CLEAR: begin
        wr_en_c   = 1'b1;
        wr_addr_c = clr_cnt;
        wr_data_c = CLEAR_VAL;
      end
      ST_IDLE: begin
        if (ld_en) begin
          wr_en_c   = 1'b1;
          wr_addr_c = ld_addr;
          wr_data_c = ld_data;
        end else if (!cs_n && !we_n) begin
          wr_en_c = 1'b1;
        end else if (!cs_n) begin
          rd_en_c = 1'b1;
        end
      end
    endcase
  end

  ram_sync_param_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (wr_addr_c),
    .wdata (wr_data_c),
    .raddr (addr),
    .rdata (rd_data_c)
  );

  assign dout_nxt_c = OUT_INV ? ~rd_data_c : rd_data_c;

  // Registered outputs; busy tracks the state the FSM is entering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b1;
    end else begin
      if (rd_en_c) dout <= dout_nxt_c;
      dout_valid <= rd_en_c;
      busy       <= (state_nxt == ST_CLEAR);
    end
  end

endmodule

// File: tb/tb_ram_sync_param.sv
// Scoreboard bench: DUT a is the default 8x16 true-data RAM, DUT b is a 4x64 inverting
// RAM with CLEAR_VAL=4'hF. Reads push expected data; negedge monitors pop and compare.
module tb_ram_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cs_n_a = 1'b1, we_n_a = 1'b1, ld_en_a = 1'b0, clear_req_a = 1'b0;
  logic [3:0] addr_a = '0, ld_addr_a = '0;
  logic [7:0] din_a = '0, ld_data_a = '0;
  logic [7:0] dout_a;
  logic       dout_valid_a, busy_a;

  logic       cs_n_b = 1'b1, we_n_b = 1'b1, ld_en_b = 1'b0, clear_req_b = 1'b0;
  logic [5:0] addr_b = '0, ld_addr_b = '0;
  logic [3:0] din_b = '0, ld_data_b = '0;
  logic [3:0] dout_b;
  logic       dout_valid_b, busy_b;

  ram_sync_param u_dut_a (
    .clk(clk), .rst(rst), .cs_n(cs_n_a), .we_n(we_n_a), .addr(addr_a), .din(din_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .ld_en(ld_en_a), .ld_addr(ld_addr_a),
    .ld_data(ld_data_a), .clear_req(clear_req_a), .busy(busy_a)
  );

  ram_sync_param #(.DATA_W(4), .ADDR_W(6), .OUT_INV(1'b1), .CLEAR_VAL(4'hF)) u_dut_b (
    .clk(clk), .rst(rst), .cs_n(cs_n_b), .we_n(we_n_b), .addr(addr_b), .din(din_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .ld_en(ld_en_b), .ld_addr(ld_addr_b),
    .ld_data(ld_data_b), .clear_req(clear_req_b), .busy(busy_b)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_a[$];
  logic [3:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitors: every read strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dout_valid_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected_valid: got dout %0h, required no strobe", dout_a);
      end else chk("a_read", 32'(dout_a), 32'(exp_a.pop_front()));
    end
    if (dout_valid_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected_valid: got dout %0h, required no strobe", dout_b);
      end else chk("b_read", 32'(dout_b), 32'(exp_b.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
    cs_n_a = 1'b0; we_n_a = 1'b0; addr_a = a; din_a = d;
    cyc();
    cs_n_a = 1'b1; we_n_a = 1'b1;
  endtask

  task automatic rd_a(input logic [3:0] a, input logic [7:0] e);
    cs_n_a = 1'b0; we_n_a = 1'b1; addr_a = a;
    exp_a.push_back(e);
    cyc();
    cs_n_a = 1'b1;
  endtask

  task automatic wr_b(input logic [5:0] a, input logic [3:0] d);
    cs_n_b = 1'b0; we_n_b = 1'b0; addr_b = a; din_b = d;
    cyc();
    cs_n_b = 1'b1; we_n_b = 1'b1;
  endtask

  task automatic rd_b(input logic [5:0] a, input logic [3:0] e);
    cs_n_b = 1'b0; we_n_b = 1'b1; addr_b = a;
    exp_b.push_back(e);
    cyc();
    cs_n_b = 1'b1;
  endtask

  // Count edges until each DUT's busy drops (bounded).
  task automatic measure_clear(input string tag);
    int ea = 0;
    int eb = 0;
    for (int i = 1; i <= 80; i++) begin
      cyc();
      if (!busy_a && ea == 0) ea = i;
      if (!busy_b && eb == 0) eb = i;
    end
    chk({tag, "_a_busy_cycles"}, 32'(ea), 32'd16);
    chk({tag, "_b_busy_cycles"}, 32'(eb), 32'd64);
  endtask

  initial begin
    int bc;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_valid_a", 32'(dout_valid_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    rst = 1'b0;

    // 1. Reset clear
    measure_clear("init");
    for (int i = 0; i < 16; i++) rd_a(4'(i), 8'h00);

    // 2. Write/read, true and inverted data
    wr_a(4'd3, 8'hA5);
    rd_a(4'd3, 8'hA5);
    wr_b(6'd3, 4'h5);
    rd_b(6'd3, 4'hA);

    // 3. Load priority over CPU write, then over CPU read
    ld_en_a = 1'b1; ld_addr_a = 4'd7; ld_data_a = 8'h3C;
    wr_a(4'd7, 8'hFF);
    ld_en_a = 1'b0;
    rd_a(4'd7, 8'h3C);
    ld_en_a = 1'b1; ld_addr_a = 4'd8; ld_data_a = 8'h77;
    cs_n_a = 1'b0; we_n_a = 1'b1; addr_a = 4'd7;
    cyc();
    cs_n_a = 1'b1; ld_en_a = 1'b0;
    @(negedge clk);
    chk("ld_drop_valid", 32'(dout_valid_a), 32'd0);
    chk("ld_drop_dout", 32'(dout_a), 32'h3C);
    rd_a(4'd8, 8'h77);

    // 4. Fill with 8'h11, clear, restart the clear after 5 cycles
    for (int i = 0; i < 16; i++) wr_a(4'(i), 8'h11);
    rd_a(4'd9, 8'h11);
    clear_req_a = 1'b1;
    rd_a(4'd0, 8'h11);
    clear_req_a = 1'b0;
    bc = 1;
    for (int i = 0; i < 40; i++) begin
      clear_req_a = (bc == 5);
      cs_n_a = 1'b0; we_n_a = i[0]; addr_a = 4'(i); din_a = 8'h99;
      cyc();
      if (busy_a) bc++;
      else break;
    end
    cs_n_a = 1'b1; we_n_a = 1'b1; clear_req_a = 1'b0;
    chk("restart_busy_cycles", 32'(bc), 32'd21);
    for (int i = 0; i < 16; i++) rd_a(4'(i), 8'h00);

    // 5. Async reset in the middle of a clear
    wr_a(4'd4, 8'h5E);
    rd_a(4'd4, 8'h5E);
    clear_req_a = 1'b1;
    cyc();
    clear_req_a = 1'b0;
    chk("clear_dout_hold", 32'(dout_a), 32'h5E);
    chk("clear_busy", 32'(busy_a), 32'd1);
    repeat (9) cyc();
    #2 rst = 1'b1;
    #1;
    chk("async_dout", 32'(dout_a), 32'd0);
    chk("async_valid", 32'(dout_valid_a), 32'd0);
    chk("async_busy_a", 32'(busy_a), 32'd1);
    chk("async_busy_b", 32'(busy_b), 32'd1);
    #2 rst = 1'b0;
    measure_clear("rerst");
    rd_a(4'd15, 8'h00);

    // 6. Wide-address, narrow-data instance with CLEAR_VAL=4'hF and inverted reads
    rd_b(6'd63, 4'h0);
    rd_b(6'd30, 4'h0);
    wr_b(6'd0, 4'h6);
    wr_b(6'd63, 4'hC);
    rd_b(6'd0, 4'h9);
    rd_b(6'd63, 4'h3);
    ld_en_b = 1'b1; ld_addr_b = 6'd40; ld_data_b = 4'h1;
    cyc();
    ld_en_b = 1'b0;
    rd_b(6'd40, 4'hE);

    repeat (3) cyc();
    chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
